// File: rtl/mic_frame_ctrl.sv
// rtl/mic_frame_ctrl.sv - PCM mic frame controller: LRCLK generation, warm-up discard, slot capture, sample handshake
module mic_frame_ctrl #(
  parameter int SLOT_BITS     = 32,
  parameter int DATA_BITS     = 18,
  parameter int WARMUP_FRAMES = 2
) (
  input  logic                 i_bclk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_chan_sel,
  input  logic                 i_d_in,
  input  logic                 i_sample_ack,
  output logic                 o_ws,
  output logic [DATA_BITS-1:0] o_sample,
  output logic                 o_sample_valid,
  output logic                 o_overrun,
  output logic                 o_running
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam int WW         = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] CNT_SLOT  = CW'(SLOT_BITS);
  localparam logic [CW-1:0] CNT_DATA  = CW'(DATA_BITS);
  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [WW-1:0]        r_warm;
  logic                 r_chan;
  logic                 r_ws;
  logic                 r_running;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_sample;
  logic                 r_valid;
  logic                 r_overrun;

  logic                 w_wrap;
  logic [CW-1:0]        w_cnt_next;
  logic [CW-1:0]        w_base;
  logic [CW-1:0]        w_pos;
  logic                 w_capture;
  logic                 w_last_bit;
  logic                 w_load;
  logic [DATA_BITS-1:0] w_word;

  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_cnt_next = w_wrap ? '0 : r_cnt + CW'(1);
  assign w_base     = r_chan ? CNT_SLOT : '0;
  // Slot-relative bit position; modulo wrap pushes the other slot far above DATA_BITS
  assign w_pos      = r_cnt - w_base;
  assign w_capture  = (r_state == ST_RUN) && i_enable && (w_pos != '0) && (w_pos <= CNT_DATA);
  assign w_last_bit = w_capture && (w_pos == CNT_DATA);
  assign w_load     = w_last_bit && (!r_valid || i_sample_ack);
  assign w_word     = {r_shift[DATA_BITS-2:0], i_d_in};

  always_ff @(posedge i_bclk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_warm    <= '0;
      r_chan    <= 1'b0;
      r_ws      <= 1'b0;
      r_running <= 1'b0;
      r_shift   <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_capture) begin
        r_shift <= w_word;
      end

      // A load on the same edge as an ack keeps the holding register full
      if (w_load) begin
        r_sample <= w_word;
        r_valid  <= 1'b1;
      end else if (i_sample_ack) begin
        r_valid  <= 1'b0;
      end

      if (w_last_bit && !w_load) begin
        r_overrun <= 1'b1;
      end

      if (!i_enable) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_warm    <= '0;
        r_ws      <= 1'b0;
        r_running <= 1'b0;
        r_shift   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // The leaving edge is the cnt=0 period of the first frame
            r_chan    <= i_chan_sel;
            r_overrun <= 1'b0;
            r_warm    <= '0;
            r_cnt     <= CW'(1);
            r_ws      <= 1'b0;
            if (WARMUP_FRAMES == 0) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end else begin
              r_state   <= ST_WARMUP;
              r_running <= 1'b0;
            end
          end
          ST_WARMUP: begin
            r_cnt <= w_cnt_next;
            r_ws  <= (w_cnt_next >= CNT_SLOT);
            if (w_wrap) begin
              if (r_warm == WARM_LAST) begin
                r_state   <= ST_RUN;
                r_running <= 1'b1;
              end else begin
                r_warm <= r_warm + WW'(1);
              end
            end
          end
          ST_RUN: begin
            r_cnt <= w_cnt_next;
            r_ws  <= (w_cnt_next >= CNT_SLOT);
          end
          default: begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ws      <= 1'b0;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_ws           = r_ws;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;
  assign o_overrun      = r_overrun;
  assign o_running      = r_running;

endmodule

// File: tb/tb_mic_frame_ctrl.sv
// tb/tb_mic_frame_ctrl.sv - randomized self-checking bench for mic_frame_ctrl against an edge-index model
module tb_mic_frame_ctrl;

  localparam int S  = 32;
  localparam int D  = 18;
  localparam int WF = 2;
  localparam int FR = 2 * S;

  logic         bclk       = 1'b0;
  logic         reset      = 1'b0;
  logic         enable     = 1'b0;
  logic         chan_sel   = 1'b0;
  logic         d_in       = 1'b0;
  logic         sample_ack = 1'b0;
  logic         ws;
  logic [D-1:0] sample;
  logic         sample_valid;
  logic         overrun;
  logic         running;

  int total = 0;
  int bad   = 0;

  // Model: m_e counts edges since the enabling edge, so the pre-edge frame position is m_e % FR
  bit           m_active   = 1'b0;
  int           m_e        = 0;
  bit           m_chan     = 1'b0;
  logic [D-1:0] m_acc      = '0;
  logic [D-1:0] m_sample   = '0;
  bit           m_valid    = 1'b0;
  bit           m_ovr      = 1'b0;
  int           m_last_cnt = 0;

  mic_frame_ctrl #(
    .SLOT_BITS(S),
    .DATA_BITS(D),
    .WARMUP_FRAMES(WF)
  ) dut (
    .i_bclk(bclk),
    .i_reset(reset),
    .i_enable(enable),
    .i_chan_sel(chan_sel),
    .i_d_in(d_in),
    .i_sample_ack(sample_ack),
    .o_ws(ws),
    .o_sample(sample),
    .o_sample_valid(sample_valid),
    .o_overrun(overrun),
    .o_running(running)
  );

  always #5 bclk = ~bclk;

  function automatic int cur_cnt();
    return m_active ? (m_e % FR) : 0;
  endfunction

  function automatic bit exp_ws();
    return m_active && ((m_e % FR) >= S);
  endfunction

  function automatic bit exp_run();
    return m_active && (m_e >= WF * FR);
  endfunction

  function automatic bit pick(input logic [D-1:0] lv, input logic [D-1:0] rv);
    int c;
    c = cur_cnt();
    if (c >= 1 && c <= D) return lv[D-c];
    if (c >= S + 1 && c <= S + D) return rv[D-(c-S)];
    return 1'($urandom);
  endfunction

  function automatic string dut_str();
    return $sformatf("ws=%b v=%b o=%b r=%b s=%h", ws, sample_valid, overrun, running, sample);
  endfunction

  function automatic string mdl_str();
    return $sformatf("ws=%b v=%b o=%b r=%b s=%h", exp_ws(), m_valid, m_ovr, exp_run(), m_sample);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_e      = 0;
    m_chan   = 1'b0;
    m_acc    = '0;
    m_sample = '0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic step(input bit en, input bit cs, input bit d, input bit ack);
    bit load;
    int pos;
    enable     = en;
    chan_sel   = cs;
    d_in       = d;
    sample_ack = ack;
    @(posedge bclk);
    load       = 1'b0;
    m_last_cnt = cur_cnt();
    if (en && m_active && m_e >= WF * FR) begin
      pos = (m_e % FR) - (m_chan ? S : 0);
      if (pos >= 1 && pos <= D) begin
        m_acc = {m_acc[D-2:0], d};
        if (pos == D) begin
          if (!m_valid || ack) begin
            m_sample = m_acc;
            load     = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
    if (load) m_valid = 1'b1;
    else if (ack) m_valid = 1'b0;
    if (!en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_e      = 1;
      m_chan   = cs;
      m_ovr    = 1'b0;
    end else begin
      m_e++;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    enable     = 1'b0;
    sample_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge bclk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge bclk);
    #1;
    total++;
    if ({ws, sample_valid, overrun, running, sample} !== '0) begin
      bad++;
      $display("FAIL reset_values got %s want all zero", dut_str());
    end
    apply_reset();
    step(0, 0, 0, 0);
    total++;
    if (ws !== 1'b0 || running !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got ws=%b r=%b want ws=0 r=0", ws, running);
    end
  endtask

  task automatic test_left_capture();
    int first = -1;
    int last_rise = -1;
    int period = -1;
    logic prev_ws = 1'b0;
    logic [D-1:0] lv;
    apply_reset();
    for (int i = 0; i < WF * FR + 3 * FR; i++) begin
      lv = exp_run() ? 18'h2A5A5 : 18'h15A5A;
      step(1, 0, pick(lv, D'($urandom)), 1);
      total++;
      if ({ws, sample_valid, overrun, running, sample} !== {exp_ws(), m_valid, m_ovr, exp_run(), m_sample}) begin
        bad++;
        $display("FAIL left_edge i=%0d got %s want %s", i, dut_str(), mdl_str());
      end
      if (sample_valid === 1'b1 && first < 0) first = i + 1;
      if (ws === 1'b1 && prev_ws === 1'b0) begin
        if (last_rise >= 0) period = i - last_rise;
        last_rise = i;
      end
      prev_ws = ws;
      if (sample_valid === 1'b1) begin
        total++;
        if (sample !== 18'h2A5A5) begin
          bad++;
          $display("FAIL left_data i=%0d got %h want 2a5a5", i, sample);
        end
      end
    end
    total++;
    if (first != WF * FR + D + 1) begin
      bad++;
      $display("FAIL left_latency got %0d want %0d", first, WF * FR + D + 1);
    end
    total++;
    if (period != FR) begin
      bad++;
      $display("FAIL ws_period got %0d want %0d", period, FR);
    end
  endtask

  task automatic test_right_capture();
    int first = -1;
    int first_cnt = -1;
    apply_reset();
    for (int i = 0; i < WF * FR + 2 * FR; i++) begin
      step(1, 1, pick(18'h00000, 18'h3FFFF), 1);
      total++;
      if ({ws, sample_valid, overrun, running, sample} !== {exp_ws(), m_valid, m_ovr, exp_run(), m_sample}) begin
        bad++;
        $display("FAIL right_edge i=%0d got %s want %s", i, dut_str(), mdl_str());
      end
      if (sample_valid === 1'b1) begin
        if (first < 0) begin
          first     = i + 1;
          first_cnt = m_last_cnt;
        end
        total++;
        if (sample !== 18'h3FFFF) begin
          bad++;
          $display("FAIL right_data i=%0d got %h want 3ffff", i, sample);
        end
      end
    end
    total++;
    if (first != WF * FR + S + D + 1) begin
      bad++;
      $display("FAIL right_latency got %0d want %0d", first, WF * FR + S + D + 1);
    end
    total++;
    if (first_cnt != S + D) begin
      bad++;
      $display("FAIL right_load_cnt got %0d want %0d", first_cnt, S + D);
    end
  endtask

  task automatic test_overrun();
    int first_ovr = -1;
    int ovr_cnt = -1;
    bit have_s0 = 1'b0;
    logic [D-1:0] s0 = '0;
    apply_reset();
    for (int i = 0; i < WF * FR + 3 * FR; i++) begin
      step(1, 0, 1'($urandom), 0);
      total++;
      if ({ws, sample_valid, overrun, running, sample} !== {exp_ws(), m_valid, m_ovr, exp_run(), m_sample}) begin
        bad++;
        $display("FAIL ovr_edge i=%0d got %s want %s", i, dut_str(), mdl_str());
      end
      if (m_valid && !have_s0) begin
        have_s0 = 1'b1;
        s0      = m_sample;
      end
      if (overrun === 1'b1 && first_ovr < 0) begin
        first_ovr = i + 1;
        ovr_cnt   = m_last_cnt;
      end
    end
    total++;
    if (first_ovr != WF * FR + FR + D + 1 || ovr_cnt != D) begin
      bad++;
      $display("FAIL ovr_timing got edge=%0d cnt=%0d want edge=%0d cnt=%0d", first_ovr, ovr_cnt, WF * FR + FR + D + 1, D);
    end
    total++;
    if (sample !== s0 || sample_valid !== 1'b1) begin
      bad++;
      $display("FAIL ovr_kept got s=%h v=%b want s=%h v=1", sample, sample_valid, s0);
    end
    repeat (3) step(0, 0, 0, 0);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL ovr_sticky_idle got %b want 1", overrun);
    end
    step(1, 0, 0, 0);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL ovr_clear got %b want 0", overrun);
    end
  endtask

  task automatic test_ack_on_load();
    logic [D-1:0] lv;
    bit ack;
    apply_reset();
    for (int i = 0; i < WF * FR + FR + D + 3; i++) begin
      lv  = (m_e < WF * FR + FR) ? 18'h12345 : 18'h2ABCD;
      ack = m_active && (m_e == WF * FR + FR + D);
      if (ack) begin
        total++;
        if (sample !== 18'h12345 || sample_valid !== 1'b1) begin
          bad++;
          $display("FAIL ack_pre_load got s=%h v=%b want s=12345 v=1", sample, sample_valid);
        end
      end
      step(1, 0, pick(lv, '0), ack);
      total++;
      if ({ws, sample_valid, overrun, running, sample} !== {exp_ws(), m_valid, m_ovr, exp_run(), m_sample}) begin
        bad++;
        $display("FAIL ack_edge i=%0d got %s want %s", i, dut_str(), mdl_str());
      end
      if (ack) begin
        total++;
        if (sample !== 18'h2ABCD || sample_valid !== 1'b1 || overrun !== 1'b0) begin
          bad++;
          $display("FAIL ack_on_load got s=%h v=%b o=%b want s=2abcd v=1 o=0", sample, sample_valid, overrun);
        end
      end
    end
    step(1, 0, 0, 1);
    total++;
    if (sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL ack_clear got v=%b want 0", sample_valid);
    end
  endtask

  task automatic test_enable_drop();
    int first = -1;
    logic [D-1:0] lv;
    apply_reset();
    for (int i = 0; i < WF * FR + FR + 10; i++) begin
      lv = (m_e < WF * FR + FR) ? 18'h0F0F0 : 18'h3C3C3;
      step(1, 0, pick(lv, '0), 0);
      total++;
      if ({ws, sample_valid, overrun, running, sample} !== {exp_ws(), m_valid, m_ovr, exp_run(), m_sample}) begin
        bad++;
        $display("FAIL drop_edge i=%0d got %s want %s", i, dut_str(), mdl_str());
      end
    end
    repeat (5) step(0, 0, 1'($urandom), 0);
    total++;
    if (ws !== 1'b0 || running !== 1'b0 || sample !== 18'h0F0F0 || sample_valid !== 1'b1) begin
      bad++;
      $display("FAIL drop_idle got %s want ws=0 r=0 v=1 s=0f0f0", dut_str());
    end
    for (int i = 0; i < WF * FR + FR + 5; i++) begin
      lv = exp_run() ? 18'h1B2C3 : 18'h0F0F0;
      step(1, 0, pick(lv, '0), 1);
      total++;
      if ({ws, sample_valid, overrun, running, sample} !== {exp_ws(), m_valid, m_ovr, exp_run(), m_sample}) begin
        bad++;
        $display("FAIL resume_edge i=%0d got %s want %s", i, dut_str(), mdl_str());
      end
      if (sample === 18'h1B2C3 && sample_valid === 1'b1 && first < 0) first = i + 1;
    end
    total++;
    if (first != WF * FR + D + 1) begin
      bad++;
      $display("FAIL resume_latency got %0d want %0d", first, WF * FR + D + 1);
    end
  endtask

  task automatic test_random();
    bit en = 1'b1;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (en && $urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      step(en, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      total++;
      if ({ws, sample_valid, overrun, running, sample} !== {exp_ws(), m_valid, m_ovr, exp_run(), m_sample}) begin
        bad++;
        $display("FAIL random_edge i=%0d got %s want %s", i, dut_str(), mdl_str());
      end
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    for (int i = 0; i < WF * FR + FR + 5; i++) begin
      step(1, 0, 1'($urandom), 0);
    end
    total++;
    if (sample_valid !== 1'b1 || running !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_state got v=%b r=%b want v=1 r=1", sample_valid, running);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({ws, sample_valid, overrun, running, sample} !== '0) begin
      bad++;
      $display("FAIL async_reset got %s want all zero", dut_str());
    end
    model_reset();
    @(posedge bclk);
    #1;
    reset = 1'b1;
    step(0, 0, 0, 0);
    total++;
    if (ws !== 1'b0 || running !== 1'b0 || sample_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle got %s want ws=0 r=0 v=0", dut_str());
    end
    step(1, 0, 0, 0);
    total++;
    if ({ws, sample_valid, overrun, running, sample} !== {exp_ws(), m_valid, m_ovr, exp_run(), m_sample}) begin
      bad++;
      $display("FAIL post_reset_enable got %s want %s", dut_str(), mdl_str());
    end
  endtask

  initial begin
    test_reset();
    test_left_capture();
    test_right_capture();
    test_overrun();
    test_ack_on_load();
    test_enable_drop();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic_frame_ctrl.md
# mic_frame_ctrl

Frame controller for the PCM microphone capture path. Runs on the microphone bit clock, generates the word-select (LRCLK) strobe, and sequences the deserializer: it selects which bit positions of the chosen channel slot are shifted in, then transfers each completed 18-bit sample to a holding register with a valid/ack handshake. It also discards start-up frames while the microphone settles and flags samples lost to a slow consumer.

## Interface
Parameters:
- SLOT_BITS, 32, bclk periods per channel slot; a frame is 2*SLOT_BITS periods
- DATA_BITS, 18, significant bits per sample, MSB first; must satisfy DATA_BITS < SLOT_BITS
- WARMUP_FRAMES, 2, complete frames discarded after enable before capture begins; 0 allowed

Ports:
- bclk  in  1  bit clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request; level-sensitive
- chan_sel  in  1  0 = capture left slot (ws=0), 1 = capture right slot (ws=1); sampled only in IDLE
- d_in  in  1  serial microphone data
- sample_ack  in  1  consumer accepts sample; meaningful only while sample_valid=1
- ws  out  1  word select to the microphone
- sample  out  DATA_BITS  last completed sample, two's complement, MSB first as received
- sample_valid  out  1  sample holds unconsumed data
- overrun  out  1  sticky: a completed sample was dropped
- running  out  1  high in RUN state

## Operation
- Reset values: ws=0, sample=0, sample_valid=0, overrun=0, running=0, state IDLE, bit counter cnt=0, warm-up counter=0, shift register=0.
- cnt: 0 .. 2*SLOT_BITS-1, wraps to 0, increments every edge outside IDLE. ws is registered and equals (cnt >= SLOT_BITS) for the current cnt value.
- Slot base B = 0 if chan_sel latched 0, else SLOT_BITS. chan_sel is latched on IDLE->WARMUP.
- States:
  - IDLE: cnt held at 0, ws=0. enable=1 -> WARMUP (or RUN if WARMUP_FRAMES=0). overrun is cleared on this transition.
  - WARMUP: cnt runs; the warm-up counter increments on each wrap. Reaching WARMUP_FRAMES -> RUN, on the wrap edge, so RUN starts at cnt=0.
  - RUN: capture active. enable=0 from any state -> IDLE on the next edge. On that edge cnt, ws, and the shift register are cleared.
- Capture (I2S one-bit delay): on an edge where the pre-edge cnt = B+k, k in 1..DATA_BITS, shift d_in into the shift register LSB. Bit position 0 and positions above DATA_BITS in the slot are ignored.
- At k = DATA_BITS, on the same edge: if sample_valid=0, or sample_ack=1 on that edge, then sample <= {shift[DATA_BITS-2:0], d_in} and sample_valid=1.
- Otherwise (sample_valid=1 and no ack) the new sample is dropped, the old sample is kept, and overrun <= 1.
- Handshake: sample_ack=1 with sample_valid=1 clears sample_valid next edge, unless a load occurs on the same edge; a load wins and sample_valid stays 1. Ack while sample_valid=0 is ignored.
- sample and sample_valid are preserved across enable=0. Only reset clears sample.

## Timing
- ws toggles on the edge that moves cnt to SLOT_BITS and on the edge that moves it to 0.
- The sample MSB is the d_in value sampled on the edge with cnt=B+1, one bclk after the ws edge.
- Latency: sample_valid rises immediately after the edge that samples the LSB (cnt=B+DATA_BITS). One sample arrives per 2*SLOT_BITS bclks.
- From enable=1 in IDLE: the first valid sample appears after (WARMUP_FRAMES*2*SLOT_BITS + B + DATA_BITS + 1) edges.
- Asynchronous reset mid-frame: all outputs go to reset values immediately, with no partial sample load.
- enable=0 during a capture slot discards the partial shift contents. No load occurs.

## Test plan
- Reset mid-RUN with sample_valid=1: all outputs 0 immediately, and after release state is IDLE with ws=0.
- enable=1, chan_sel=0, WARMUP_FRAMES=2, left-slot data 18'h2A5A5 driven MSB-first at cnt 1..18 (garbage at cnt 0, 19..63), sample_ack tied 1: ws period is 64 bclk. sample=18'h2A5A5 with valid first asserted after 147 edges; warm-up frame data never appears.
- chan_sel=1, right slot 18'h3FFFF, left slot 18'h00000: sample=18'h3FFFF, valid after edge at cnt=50, and left data is never captured.
- sample_ack held 0 across two frames: the first sample is kept, overrun=1 after the second frame's cnt=18 edge and stays 1 until the next IDLE->WARMUP.
- sample_ack asserted exactly on the load edge: new sample loaded, sample_valid stays 1, overrun stays 0.
- enable dropped at cnt=10 in RUN, then re-raised: no load from the partial slot, ws=0 in IDLE, previous sample retained, and capture resumes after 2 warm-up frames.
